// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;

  always_comb begin
    // rot[0] is the requester sitting at the pointer, so the lowest set bit wins
    for (int i = 0; i < NREQ; i++) begin
      int src;
      src = i + int'(ptr_i);
      if (src >= NREQ) src = src - NREQ;
      rot[i] = valid_i[src];
    end
    found_o = |rot;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IDW + 1)'(NREQ)) sum = sum - (IDW + 1)'(NREQ);
    idx_o = sum[IDW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers,
// with bounded bursts and full-flag back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  input  logic [NREQ-1:0]               req_last,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [WIDTH-1:0]              fifo_data_in,
  output logic [id_width(NREQ)-1:0]     grant_id,
  output logic                          busy
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = cnt_width(MAX_BURST);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           in_grant, own_valid, xfer, burst_done, release_now;
  logic [IDW-1:0] ptr_after_owner;
  logic [WIDTH-1:0] data_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_slice[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    in_grant   = (state_q == ARB_GRANT);
    own_valid  = req_valid[owner_q];
    xfer       = in_grant & own_valid & ~fifo_full;
    burst_done = (cnt_q == CW'(MAX_BURST - 1));
    // full alone never releases; an idle owner only releases when it could have sent
    release_now = in_grant & ((xfer & (req_last[owner_q] | burst_done)) | (~own_valid & ~fifo_full));
    ptr_after_owner = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    req_ready = '0;
    if (in_grant && !fifo_full) req_ready[owner_q] = 1'b1;
    fifo_w_en    = xfer;
    fifo_data_in = in_grant ? data_slice[owner_q] : '0;

    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_after_owner;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ARB_GRANT);
  assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4, WIDTH = 8, MAX_BURST = 4, FIFO_DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full = 1'b0;
  logic                  fifo_w_en;
  logic [WIDTH-1:0]      fifo_data_in;
  logic [1:0]            grant_id;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where the round-robin search starts, beats so far
  bit m_ok = 1'b0;
  bit m_busy;
  int m_owner, m_ptr, m_beats;
  logic [3:0] e_rdy;
  logic       e_wen;
  logic [7:0] e_dat;

  logic       o_busy, o_wen;
  logic [1:0] o_gid;
  logic [3:0] o_rdy;
  logic [7:0] o_dat;

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [3:0] l;
    bit         f;
    bit         busy;
    logic [1:0] gid;
    logic [3:0] rdy;
    bit         wen;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_out();
    e_rdy = '0;
    e_wen = 1'b0;
    e_dat = '0;
    if (m_busy) begin
      e_dat = req_data[m_owner*WIDTH +: WIDTH];
      if (!fifo_full) begin
        e_rdy[m_owner] = 1'b1;
        e_wen = req_valid[m_owner];
      end
    end
  endtask

  task automatic model_release();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % NREQ;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_busy) begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && req_valid[c]) begin
          found = 1'b1; m_owner = c; m_beats = 0; m_busy = 1'b1;
        end
      end
    end else if (!fifo_full) begin
      if (req_valid[m_owner]) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MAX_BURST) model_release();
      end else begin
        model_release();
      end
    end
  endtask

  // One clock: drive at negedge, compare just after, advance the model at posedge
  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic f, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; req_valid = v; req_last = l; fifo_full = f; req_data = d;
    #1;
    model_out();
    o_busy = busy; o_gid = grant_id; o_rdy = req_ready; o_wen = fifo_w_en; o_dat = fifo_data_in;
    if (m_ok) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_owner));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("fifo_w_en", 32'(fifo_w_en), 32'(e_wen));
      chk("fifo_data_in", 32'(fifo_data_in), 32'(e_dat));
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    cyc(1'b0, 4'hF, 4'h0, 1'b0, $urandom);
    cyc(1'b0, 4'hF, 4'h0, 1'b0, $urandom);
  endtask

  initial begin
    int wr[NREQ];
    int starts[$];
    bit prev_busy;
    int cnt;
    int fifo_cnt;
    bit force_full;
    logic [3:0] rv, rl;

    tbl[0]  = '{1, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00};
    tbl[1]  = '{1, 4'b0010, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00};
    tbl[2]  = '{1, 4'b0010, 4'b0000, 0, 1, 2'd1, 4'b0010, 1, 8'hA1};
    tbl[3]  = '{1, 4'b0010, 4'b0000, 0, 1, 2'd1, 4'b0010, 1, 8'hA1};
    tbl[4]  = '{1, 4'b0010, 4'b0010, 0, 1, 2'd1, 4'b0010, 1, 8'hA1};
    tbl[5]  = '{1, 4'b0011, 4'b0000, 0, 0, 2'd1, 4'b0000, 0, 8'h00};
    tbl[6]  = '{1, 4'b0011, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 8'hA0};
    tbl[7]  = '{1, 4'b0011, 4'b0000, 0, 1, 2'd0, 4'b0001, 1, 8'hA0};
    tbl[8]  = '{1, 4'b0011, 4'b0000, 0, 1, 2'd0, 4'b0001, 1, 8'hA0};
    tbl[9]  = '{1, 4'b0011, 4'b0000, 0, 1, 2'd0, 4'b0001, 1, 8'hA0};
    tbl[10] = '{1, 4'b0011, 4'b0000, 0, 1, 2'd0, 4'b0001, 1, 8'hA0};
    tbl[11] = '{1, 4'b0011, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00};
    tbl[12] = '{1, 4'b0001, 4'b0000, 0, 1, 2'd1, 4'b0010, 0, 8'hA1};
    tbl[13] = '{1, 4'b0001, 4'b0000, 0, 0, 2'd1, 4'b0000, 0, 8'h00};
    tbl[14] = '{1, 4'b0000, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 8'hA0};
    tbl[15] = '{1, 4'b0000, 4'b0000, 0, 1, 2'd0, 4'b0001, 0, 8'hA0};
    tbl[16] = '{1, 4'b1000, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00};
    tbl[17] = '{1, 4'b1000, 4'b1000, 0, 1, 2'd3, 4'b1000, 1, 8'hA3};
    tbl[18] = '{1, 4'b0000, 4'b0000, 0, 0, 2'd3, 4'b0000, 0, 8'h00};
    tbl[19] = '{0, 4'b1111, 4'b0000, 0, 0, 2'd3, 4'b0000, 0, 8'h00};
    tbl[20] = '{1, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00};

    // Reset held two cycles with every requester valid
    do_reset();
    chk("reset.busy", 32'(o_busy), 32'd0);
    chk("reset.grant_id", 32'(o_gid), 32'd0);
    chk("reset.req_ready", 32'(o_rdy), 32'd0);
    chk("reset.fifo_w_en", 32'(o_wen), 32'd0);
    chk("reset.fifo_data_in", 32'(o_dat), 32'd0);

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].f, 32'hA3A2A1A0);
      chk($sformatf("tbl[%0d].busy", i), 32'(o_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d].grant_id", i), 32'(o_gid), 32'(tbl[i].gid));
      chk($sformatf("tbl[%0d].req_ready", i), 32'(o_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl[%0d].fifo_w_en", i), 32'(o_wen), 32'(tbl[i].wen));
      chk($sformatf("tbl[%0d].fifo_data_in", i), 32'(o_dat), 32'(tbl[i].d));
    end
    $display("table: %0d vectors applied", 21);

    // Fairness: all valid, no last -> grants 0,1,2,3,0 with four writes each
    do_reset();
    for (int i = 0; i < NREQ; i++) wr[i] = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc(1'b1, 4'hF, 4'h0, 1'b0, $urandom);
      if (o_busy && !prev_busy) starts.push_back(int'(o_gid));
      if (c < 21 && o_wen) wr[o_gid]++;
      prev_busy = o_busy;
    end
    chk("fair.grants", 32'(starts.size()), 32'd5);
    for (int i = 0; i < starts.size() && i < 5; i++)
      chk($sformatf("fair.order[%0d]", i), 32'(starts[i]), 32'(i % NREQ));
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("fair.writes[%0d]", i), 32'(wr[i]), 32'd4);
    $display("fairness: grant order captured, %0d grants", starts.size());

    // Full stall mid-burst on requester 0
    do_reset();
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      cyc(1'b1, 4'b0001, 4'h0, (c >= 3 && c <= 5), $urandom);
      if (o_wen) cnt++;
      if (c >= 3 && c <= 5) begin
        chk("stall.req_ready", 32'(o_rdy), 32'd0);
        chk("stall.fifo_w_en", 32'(o_wen), 32'd0);
        chk("stall.grant_id", 32'(o_gid), 32'd0);
        chk("stall.busy", 32'(o_busy), 32'd1);
      end
    end
    chk("stall.beats", 32'(cnt), 32'd4);
    chk("stall.released", 32'(o_busy), 32'd0);
    $display("full stall: %0d beats written", cnt);

    // Valid drop: requester 2 sends two beats then goes away while 3 waits
    do_reset();
    cnt = 0;
    cyc(1'b1, 4'b0100, 4'h0, 1'b0, $urandom);
    cyc(1'b1, 4'b1100, 4'h0, 1'b0, $urandom);
    if (o_wen && o_gid == 2'd2) cnt++;
    cyc(1'b1, 4'b1100, 4'h0, 1'b0, $urandom);
    if (o_wen && o_gid == 2'd2) cnt++;
    cyc(1'b1, 4'b1000, 4'h0, 1'b0, $urandom);
    if (o_wen && o_gid == 2'd2) cnt++;
    cyc(1'b1, 4'b1000, 4'h0, 1'b0, $urandom);
    chk("drop.bubble", 32'(o_busy), 32'd0);
    cyc(1'b1, 4'b1000, 4'h0, 1'b0, $urandom);
    chk("drop.next_busy", 32'(o_busy), 32'd1);
    chk("drop.next_grant", 32'(o_gid), 32'd3);
    chk("drop.req2_words", 32'(cnt), 32'd2);
    $display("valid drop: req2 wrote %0d words", cnt);

    // Reset mid-burst on requester 1, then req0 wins from the reset pointer
    do_reset();
    cyc(1'b1, 4'b0010, 4'h0, 1'b0, $urandom);
    cyc(1'b1, 4'b0010, 4'h0, 1'b0, $urandom);
    cyc(1'b0, 4'b0010, 4'h0, 1'b0, $urandom);
    cyc(1'b1, 4'b0011, 4'h0, 1'b0, $urandom);
    chk("rstmid.busy", 32'(o_busy), 32'd0);
    chk("rstmid.req_ready", 32'(o_rdy), 32'd0);
    cyc(1'b1, 4'b0011, 4'h0, 1'b0, $urandom);
    chk("rstmid.grant_busy", 32'(o_busy), 32'd1);
    chk("rstmid.grant_id", 32'(o_gid), 32'd0);
    $display("reset mid-burst: next grant %0d", o_gid);

    // Random traffic against the model, FIFO occupancy tracked with random draining
    fifo_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rv = '0;
      rl = '0;
      for (int i = 0; i < NREQ; i++) begin
        rv[i] = ($urandom_range(0, 99) < 80);
        rl[i] = ($urandom_range(0, 99) < 25);
      end
      force_full = ($urandom_range(0, 99) < 10);
      cyc(($urandom_range(0, 199) != 0), rv, rl, (fifo_cnt >= FIFO_DEPTH) || force_full, $urandom);
      if (e_wen && m_ok) fifo_cnt++;
      if (fifo_cnt > 0 && $urandom_range(0, 99) < 45) fifo_cnt--;
    end
    $display("random: 3000 cycles, %0d checks so far", checks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
